// File: rtl/opentdc_pkg.sv
// opentdc_pkg
//   Shared helpers for the OpenTDC readout path.
//   - clog2       : ceiling log2 for parameter derivation
//   - chan_w      : channel-id width, at least 1 bit
//   - level_w     : width of an occupancy counter that can hold DEPTH
//   - entry_w     : width of one readout FIFO entry
//   FIFO entry layout: {chan_id[CW-1:0], timestamp[DW-1:0]}. The channel id
//   sits in the upper CW bits and the timestamp in the lower DW bits.
package opentdc_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  function automatic int chan_w(input int nchan);
    return (clog2(nchan) < 1) ? 1 : clog2(nchan);
  endfunction

  function automatic int level_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic int entry_w(input int nchan, input int dw);
    return chan_w(nchan) + dw;
  endfunction

endpackage

// File: rtl/opentdc_rr_arbiter.sv
// opentdc_rr_arbiter
//   Purely combinational round-robin arbiter. Searches req upward starting
//   at ptr, wrapping modulo N, and reports the first set bit.
//   Ports:
//     req   in  N   request vector
//     ptr   in  IW  search start position (0..N-1)
//     grant out N   one-hot grant (all zero when no request)
//     idx   out IW  index of the granted requester (0 when none)
//     any   out 1   at least one request present
module opentdc_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin : scan
    int k;
    // NOTE: every output gets a default before the search loop so no path
    // leaves a value unassigned and no latch is inferred.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        any      = 1'b1;
        idx      = IW'(k);
        grant[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/opentdc_readout_arb.sv
// opentdc_readout_arb
//   Shares one readout path between NCHAN TDC channel cores. A round-robin
//   arbiter grants one valid, enabled channel per cycle and pushes
//   {channel id, timestamp} into a show-ahead FIFO popped by the Wishbone
//   side.
//   Ports:
//     wb_clk_i      in   1          clock, rising edge
//     wb_rst_i      in   1          asynchronous active-high reset
//     chan_valid_i  in   NCHAN      per-channel timestamp available
//     chan_data_i   in   NCHAN*DW   timestamps, channel k at [k*DW +: DW]
//     chan_ack_o    out  NCHAN      one-hot grant/consume pulse
//     chan_en_i     in   NCHAN      per-channel enable mask
//     pop_i         in   1          consume head entry
//     head_data_o   out  DW         head timestamp (0 while empty)
//     head_chan_o   out  CW         head channel id (0 while empty)
//     empty_o       out  1          FIFO empty
//     full_o        out  1          FIFO full
//     level_o       out  LW         occupancy
//     stall_cnt_o   out  16         saturating blocked-request cycle count
//     stall_clr_i   in   1          synchronous clear of stall_cnt_o
module opentdc_readout_arb
  import opentdc_pkg::*;
#(
  parameter int NCHAN = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  localparam int CW   = chan_w(NCHAN),
  localparam int LW   = level_w(DEPTH)
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [NCHAN-1:0]    chan_valid_i,
  input  logic [NCHAN*DW-1:0] chan_data_i,
  output logic [NCHAN-1:0]    chan_ack_o,
  input  logic [NCHAN-1:0]    chan_en_i,
  input  logic                pop_i,
  output logic [DW-1:0]       head_data_o,
  output logic [CW-1:0]       head_chan_o,
  output logic                empty_o,
  output logic                full_o,
  output logic [LW-1:0]       level_o,
  output logic [15:0]         stall_cnt_o,
  input  logic                stall_clr_i
);

  localparam int AW = clog2(DEPTH);
  localparam int EW = entry_w(NCHAN, DW);

  logic [NCHAN-1:0] req;
  logic [NCHAN-1:0] grant;
  logic [CW-1:0]    grant_idx;
  logic             any_req;
  logic [CW-1:0]    rr_ptr;
  logic             can_push;
  logic             push;
  logic             pop;
  logic [DW-1:0]    sel_data;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    head;

  assign req = chan_valid_i & chan_en_i;

  opentdc_rr_arbiter #(
    .N  (NCHAN),
    .IW (CW)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (any_req)
  );

  assign full_o   = (level_o == LW'(DEPTH));
  assign empty_o  = (level_o == '0);
  // A pop in the same cycle frees the slot the push needs, so a full FIFO
  // can still accept a grant.
  assign can_push = !full_o || pop_i;
  // Reset also suppresses the combinational grant so no channel sees an ack
  // that the (held-in-reset) FIFO would then discard.
  assign push     = any_req && can_push && !wb_rst_i;
  assign pop      = pop_i && !empty_o;

  assign chan_ack_o = push ? grant : '0;
  assign sel_data   = chan_data_i[int'(grant_idx)*DW +: DW];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_o     <= '0;
      rr_ptr      <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (grant_idx == CW'(NCHAN - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_o <= level_o + 1'b1;
        2'b01:   level_o <= level_o - 1'b1;
        default: level_o <= level_o;
      endcase
      if (stall_clr_i) begin
        stall_cnt_o <= '0;
      end else if (any_req && !can_push && (stall_cnt_o != 16'hFFFF)) begin
        stall_cnt_o <= stall_cnt_o + 16'd1;
      end
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by level_o
  // and the head outputs are forced to zero while empty, so stale contents
  // are never observable.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {grant_idx, sel_data};
    end
  end

  assign head        = mem[rd_ptr];
  assign head_data_o = empty_o ? '0 : head[DW-1:0];
  assign head_chan_o = empty_o ? '0 : head[EW-1 -: CW];

endmodule

// File: tb/tb_opentdc_readout_arb.sv
// tb_opentdc_readout_arb
//   Self-checking bench for opentdc_readout_arb with NCHAN=4, DW=32, DEPTH=4.
//   Expected acks come from a vector table and hand-written sequences; a
//   queue scoreboard holds the entries the bench expects in the FIFO and is
//   compared against the show-ahead head and the occupancy.
module tb_opentdc_readout_arb;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   valid = '0;
  logic [3:0]   en = 4'hF;
  logic         pop = 1'b0;
  logic         clr = 1'b0;
  logic [31:0]  cd [4];
  logic [127:0] chan_data;

  logic [3:0]   ack;
  logic [31:0]  head_data;
  logic [1:0]   head_chan;
  logic         empty;
  logic         full;
  logic [2:0]   level;
  logic [15:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic [3:0] v;
    logic [3:0] en;
    logic       p;
    logic       c;
    logic [3:0] ack;
    string      name;
  } vec_t;

  ent_t sb [$];
  vec_t tbl [$];

  always #5 clk = ~clk;

  assign chan_data = {cd[3], cd[2], cd[1], cd[0]};

  opentdc_readout_arb #(
    .NCHAN (4),
    .DW    (32),
    .DEPTH (4)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .chan_valid_i (valid),
    .chan_data_i  (chan_data),
    .chan_ack_o   (ack),
    .chan_en_i    (en),
    .pop_i        (pop),
    .head_data_o  (head_data),
    .head_chan_o  (head_chan),
    .empty_o      (empty),
    .full_o       (full),
    .level_o      (level),
    .stall_cnt_o  (stall_cnt),
    .stall_clr_i  (clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs (called at posedge+1), compare the
  // combinational ack and head, update the scoreboard, then compare the
  // registered occupancy flags after the edge.
  task automatic cycle(input logic [3:0] v, input logic [3:0] e, input logic p,
                       input logic c, input logic [3:0] exp_ack, input string name);
    ent_t ent;
    valid = v;
    en    = e;
    pop   = p;
    clr   = c;
    #1;
    check({name, " ack"}, 32'(ack), 32'(exp_ack));
    if (sb.size() > 0) begin
      check({name, " head_chan"}, 32'(head_chan), 32'(sb[0].ch));
      check({name, " head_data"}, head_data, sb[0].d);
      if (p) void'(sb.pop_front());
    end else begin
      check({name, " empty"}, 32'(empty), 32'd1);
      check({name, " head_zero"}, head_data, 32'd0);
    end
    if (exp_ack != 4'b0000) begin
      ent.ch = 2'd0;
      for (int k = 0; k < 4; k++) begin
        if (exp_ack[k]) ent.ch = 2'(k);
      end
      ent.d = cd[ent.ch];
      sb.push_back(ent);
    end
    @(posedge clk);
    #1;
    check({name, " level"}, 32'(level), 32'(sb.size()));
    check({name, " full"}, 32'(full), 32'(sb.size() == 4));
  endtask

  initial begin
    cd[0] = 32'hA000_0000;
    cd[1] = 32'h0000_1234;
    cd[2] = 32'hC000_0002;
    cd[3] = 32'hD000_0003;

    // Round robin with a pop every cycle: the FIFO never fills.
    tbl.push_back('{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0001, "rr0"});
    tbl.push_back('{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0010, "rr1"});
    tbl.push_back('{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0100, "rr2"});
    tbl.push_back('{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1000, "rr3"});
    tbl.push_back('{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0001, "rr4"});
    tbl.push_back('{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0010, "rr5"});
    tbl.push_back('{4'b0000, 4'b1111, 1'b1, 1'b0, 4'b0000, "rr_drain"});
    // Single channel 1 with data 0x1234, no pop.
    tbl.push_back('{4'b0010, 4'b1111, 1'b0, 1'b0, 4'b0010, "single"});
    tbl.push_back('{4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0000, "single_hold"});
    // Channel 2 masked off: never acked; then pop to empty and pop on empty.
    tbl.push_back('{4'b0100, 4'b1011, 1'b0, 1'b0, 4'b0000, "mask0"});
    tbl.push_back('{4'b0100, 4'b1011, 1'b0, 1'b0, 4'b0000, "mask1"});
    tbl.push_back('{4'b0100, 4'b1011, 1'b1, 1'b0, 4'b0000, "mask_pop"});
    tbl.push_back('{4'b0100, 4'b1011, 1'b1, 1'b0, 4'b0000, "empty_pop"});
    tbl.push_back('{4'b0100, 4'b1011, 1'b1, 1'b0, 4'b0000, "empty_pop2"});

    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst ack", 32'(ack), 32'd0);
    check("rst empty", 32'(empty), 32'd1);
    check("rst full", 32'(full), 32'd0);
    check("rst level", 32'(level), 32'd0);
    check("rst stall", 32'(stall_cnt), 32'd0);
    check("rst head_data", head_data, 32'd0);
    check("rst head_chan", 32'(head_chan), 32'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].en, tbl[i].p, tbl[i].c, tbl[i].ack, tbl[i].name);
    end
    check("no stall after rr/mask", 32'(stall_cnt), 32'd0);

    // Back-pressure: rr_ptr is 2 here. Fill four entries.
    cycle(4'b0001, 4'hF, 1'b0, 1'b0, 4'b0001, "fill0");
    cycle(4'b0010, 4'hF, 1'b0, 1'b0, 4'b0010, "fill1");
    cycle(4'b0100, 4'hF, 1'b0, 1'b0, 4'b0100, "fill2");
    cycle(4'b0001, 4'hF, 1'b0, 1'b0, 4'b0001, "fill3");
    for (int i = 0; i < 10; i++) begin
      cycle(4'b1000, 4'hF, 1'b0, 1'b0, 4'b0000, "blocked");
    end
    check("stall after 10", 32'(stall_cnt), 32'd10);
    cycle(4'b1000, 4'hF, 1'b0, 1'b1, 4'b0000, "clr_vs_stall");
    check("stall clr priority", 32'(stall_cnt), 32'd0);
    cycle(4'b1000, 4'hF, 1'b0, 1'b0, 4'b0000, "blocked_again");
    check("stall recount", 32'(stall_cnt), 32'd1);
    cycle(4'b1000, 4'hF, 1'b1, 1'b0, 4'b1000, "push_pop_full");
    check("stall on push_pop", 32'(stall_cnt), 32'd1);
    cycle(4'b0000, 4'hF, 1'b1, 1'b1, 4'b0000, "drain0");
    cycle(4'b0000, 4'hF, 1'b1, 1'b0, 4'b0000, "drain1");
    cycle(4'b0000, 4'hF, 1'b1, 1'b0, 4'b0000, "drain2");
    cycle(4'b0000, 4'hF, 1'b1, 1'b0, 4'b0000, "drain3");
    check("stall cleared", 32'(stall_cnt), 32'd0);

    // Reset mid-traffic with three entries queued (rr_ptr is 0 here).
    cycle(4'b0001, 4'hF, 1'b0, 1'b0, 4'b0001, "q0");
    cycle(4'b0010, 4'hF, 1'b0, 1'b0, 4'b0010, "q1");
    cycle(4'b0100, 4'hF, 1'b0, 1'b0, 4'b0100, "q2");
    rst   = 1'b1;
    valid = 4'b1000;
    pop   = 1'b0;
    #1;
    check("midrst ack", 32'(ack), 32'd0);
    check("midrst empty", 32'(empty), 32'd1);
    check("midrst level", 32'(level), 32'd0);
    check("midrst head_data", head_data, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    check("midrst hold ack", 32'(ack), 32'd0);
    rst = 1'b0;
    // rr_ptr back at 0 picks ch1 out of {1,3}; then a lone ch2 request.
    cycle(4'b1010, 4'hF, 1'b0, 1'b0, 4'b0010, "post_rst_ptr");
    cycle(4'b0100, 4'hF, 1'b0, 1'b0, 4'b0100, "post_rst_ch2");

    // Saturation: fill, then hold every channel blocked for 70000 cycles.
    cycle(4'b1000, 4'hF, 1'b0, 1'b0, 4'b1000, "sat_fill0");
    cycle(4'b0001, 4'hF, 1'b0, 1'b0, 4'b0001, "sat_fill1");
    valid = 4'b1111;
    pop   = 1'b0;
    clr   = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    check("stall 0xfffe", 32'(stall_cnt), 32'hFFFE);
    check("sat ack", 32'(ack), 32'd0);
    repeat (4466) @(posedge clk);
    #1;
    check("stall saturated", 32'(stall_cnt), 32'hFFFF);
    check("sat level", 32'(level), 32'd4);
    check("sat full", 32'(full), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/opentdc_readout_arb.md
Name: opentdc_readout_arb

Overview:
- Shares one readout path between NCHAN TDC channel cores.
- Each channel presents a captured timestamp with a valid/ack handshake. A round-robin arbiter grants one channel per cycle and pushes {channel id, timestamp} into a small show-ahead FIFO.
- The Wishbone slave logic pops the FIFO on read. The block sits between the TDC channels and the Wishbone register decode inside opentdc_wb.

Parameters:
- NCHAN, 4, number of requesting TDC channels (2..8).
- DW, 32, timestamp width per channel.
- DEPTH, 4, FIFO entries; power of 2, at least 2.

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- chan_valid_i  in  NCHAN  per-channel timestamp available; held until acked.
- chan_data_i  in  NCHAN*DW  timestamps; channel k occupies bits [k*DW +: DW].
- chan_ack_o  out  NCHAN  one-hot, one-cycle grant/consume pulse.
- chan_en_i  in  NCHAN  per-channel enable mask; a disabled channel is never granted.
- pop_i  in  1  consume the head FIFO entry.
- head_data_o  out  DW  head timestamp (show-ahead).
- head_chan_o  out  CW  channel id of head entry; CW = max(1, clog2(NCHAN)).
- empty_o  out  1  FIFO empty.
- full_o  out  1  FIFO full.
- level_o  out  clog2(DEPTH)+1  current occupancy.
- stall_cnt_o  out  16  saturating count of cycles with a pending enabled request that was blocked by full.
- stall_clr_i  in  1  synchronous clear of stall_cnt_o.

Behaviour:
- Reset (async assert, sync-safe deassert on wb_clk_i):
  - FIFO pointers = 0; level_o = 0; empty_o = 1; full_o = 0.
  - chan_ack_o = 0; rr_ptr = 0; stall_cnt_o = 0.
  - head_data_o = 0 and head_chan_o = 0 while empty.
- Request vector: req = chan_valid_i & chan_en_i.
- Space condition: can_push = !full_o | pop_i. Push while full is allowed when a pop occurs in the same cycle.
- Grant, per cycle:
  - If req != 0 and can_push, grant g = first set bit of req searching upward from rr_ptr, wrapping modulo NCHAN.
  - Combinationally assert chan_ack_o[g] = 1 in that same cycle.
  - At the clock edge, write {g, chan_data_i[g]} to the FIFO and set rr_ptr = (g+1) mod NCHAN.
  - Otherwise chan_ack_o = 0 and rr_ptr is unchanged.
- Channel contract: data must stay stable while valid=1 and ack=0. After ack, a channel may drop valid or present new data on the next cycle.
- Push latency: an entry pushed at edge N is visible on head_* and clears empty_o after edge N (0-cycle show-ahead once written).
- Pop:
  - pop_i with empty_o = 1 is ignored; no pointer change and no underflow.
  - Simultaneous push and pop leaves level unchanged, and the head advances.
  - With level = 1 and simultaneous push and pop, the new entry becomes head next cycle.
- full_o = (level_o == DEPTH).
- Pointers: width clog2(DEPTH), natural wrap-around. Level tracks with a separate counter; full and empty are never derived from pointer equality alone.
- Stall counter:
  - Increments when req != 0 and !can_push; saturates at 0xFFFF.
  - stall_clr_i has priority over increment in the same cycle.
- Disabled channel: deasserting chan_en_i while that channel is valid makes it invisible to arbitration. Entries already queued are unaffected.
- Reset mid-operation discards all queued entries and any pending grant. Channels must re-present their data.
- Fairness: with all NCHAN enabled and continuously valid and no back-pressure, grants cycle 0,1,..,NCHAN-1,0 with no repeats.

Decomposition:
- Shared package opentdc_pkg holds the clog2 function, CW/level width derivation, and the FIFO entry field layout (chan id in upper CW bits, timestamp in lower DW bits).
- One sub-module: opentdc_rr_arbiter (req, rr_ptr in; one-hot grant, grant index, any_grant out), purely combinational and reusable by other shared TDC resources.
- The FIFO stays inline in opentdc_readout_arb.

Test Plan:
- Reset: after wb_rst_i pulse mid-traffic with 3 queued entries -> next cycle empty_o=1, level_o=0, chan_ack_o=0; a subsequent single request from ch2 is granted first.
- Single channel: ch1 valid with data 0x0000_1234, pop_i=0 -> ack[1] pulse for 1 cycle; next cycle head_chan_o=1, head_data_o=0x0000_1234, level_o=1.
- Round robin: ch0..ch3 all valid continuously, pop_i=1 every cycle -> ack order 0,1,2,3,0,1; FIFO never fills; stall_cnt_o stays 0.
- Full/back-pressure: DEPTH=4, fill with 4 entries, ch3 valid, pop_i=0 for 10 cycles -> no ack, full_o=1, stall_cnt_o=10. Then pop_i=1 for one cycle -> ack[3] in that cycle and level_o stays 4.
- Mask and empty pop: chan_en_i=4'b1011, ch2 valid -> never acked. pop_i on empty -> level_o stays 0. stall_clr_i together with a stall cycle -> stall_cnt_o=0.
- Stall saturation: force 70000 blocked cycles -> stall_cnt_o=0xFFFF, no wrap.
